traffic_phase_sched: RTL

//  Phase scheduler for a two-road intersection: sequences the red/yellow/green lamps of road 1 and road 2.

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/traffic_cnt_calc.sv | 51 +++++
 rtl/traffic_phase_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the two-road intersection phase scheduler.
//   phase_t      : phase ring G1 -> Y1 -> AR_A -> G2 -> Y2 -> AR_B, plus FLASH
//   DEF_*        : default phase durations in 1 s ticks
//   LAMP_*       : lamp vectors, bit order {xanh_1,vang_1,do_1,xanh_2,vang_2,do_2}
//   lamp_for()   : lamp vector for a given phase and flash phase
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        G1    = 3'd0,
        Y1    = 3'd1,
        AR_A  = 3'd2,
        G2    = 3'd3,
        Y2    = 3'd4,
        AR_B  = 3'd5,
        FLASH = 3'd6
    } phase_t;

    localparam int DEF_T_GREEN     = 6;
    localparam int DEF_T_GREEN_MIN = 3;
    localparam int DEF_T_YELLOW    = 3;
    localparam int DEF_T_ALLRED    = 1;
    localparam int DEF_CNT_W       = 5;

    localparam logic [5:0] LAMP_G1 = 6'b100_001;
    localparam logic [5:0] LAMP_Y1 = 6'b010_001;
    localparam logic [5:0] LAMP_G2 = 6'b001_100;
    localparam logic [5:0] LAMP_Y2 = 6'b001_010;
    localparam logic [5:0] LAMP_AR = 6'b001_001;

    // In FLASH only the two yellow lamps are lit, both following flash_ph.
    function automatic logic [5:0] lamp_for(input phase_t p, input logic flash_ph);
        logic [5:0] lamps;
        case (p)
            G1:      lamps = LAMP_G1;
            Y1:      lamps = LAMP_Y1;
            G2:      lamps = LAMP_G2;
            Y2:      lamps = LAMP_Y2;
            FLASH:   lamps = {1'b0, flash_ph, 1'b0, 1'b0, flash_ph, 1'b0};
            default: lamps = LAMP_AR;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_cnt_calc.sv
// ---------------------------------------------------------------------------
// traffic_cnt_calc
// Combinational "seconds until this road's lamp changes" for one road.
// Instantiated once per road; ROAD selects which side of the ring is "own".
//   state      in  phase_t   current scheduler phase
//   phase_left in  CNT_W     ticks left in the current phase
//   cnt        out CNT_W     countdown, saturating at all-ones, 0 in FLASH
// ---------------------------------------------------------------------------
module traffic_cnt_calc
    import traffic_pkg::*;
#(
    parameter int ROAD     = 1,
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_ALLRED = DEF_T_ALLRED,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  phase_t             state,
    input  logic [CNT_W-1:0]   phase_left,
    output logic [CNT_W-1:0]   cnt
);

    // Offsets added to phase_left when this road is waiting on the other one.
    localparam logic [CNT_W:0] ADD_OTHER_G  = (CNT_W+1)'(T_YELLOW + T_ALLRED);
    localparam logic [CNT_W:0] ADD_OTHER_Y  = (CNT_W+1)'(T_ALLRED);
    localparam logic [CNT_W:0] ADD_FULL_RED = (CNT_W+1)'(T_GREEN + T_YELLOW + T_ALLRED);

    localparam bit IS_ROAD1 = (ROAD == 1);

    logic [CNT_W:0] pl_ext;
    logic [CNT_W:0] sum;

    assign pl_ext = {1'b0, phase_left};

    // The sum is one bit wider than the output so an overflow can be
    // detected and clamped instead of wrapping around on the display.
    always_comb begin
        sum = '0;
        case (state)
            G1:      sum = IS_ROAD1 ? pl_ext : pl_ext + ADD_OTHER_G;
            Y1:      sum = IS_ROAD1 ? pl_ext : pl_ext + ADD_OTHER_Y;
            G2:      sum = IS_ROAD1 ? pl_ext + ADD_OTHER_G : pl_ext;
            Y2:      sum = IS_ROAD1 ? pl_ext + ADD_OTHER_Y : pl_ext;
            AR_A:    sum = IS_ROAD1 ? pl_ext + ADD_FULL_RED : pl_ext;
            AR_B:    sum = IS_ROAD1 ? pl_ext : pl_ext + ADD_FULL_RED;
            default: sum = '0;
        endcase
        cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// ---------------------------------------------------------------------------
// traffic_phase_sched
// Phase scheduler for a two-road intersection, driven by a 1 Hz tick enable.
// Sequences the lamps of both roads, serves a latched pedestrian request by
// cutting the current green early and lighting the walk lamp in the following
// all-red, and supports a night flashing-yellow mode.
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   tick_1s     in   one-clk pulse per second
//   ped_req     in   pedestrian button (level or pulse)
//   night_mode  in   1 = request flashing-yellow operation
//   xanh_1/vang_1/do_1  out  road 1 green/yellow/red lamp (registered)
//   xanh_2/vang_2/do_2  out  road 2 green/yellow/red lamp (registered)
//   ped_walk    out  walk lamp (registered)
//   cnt_1/cnt_2 out  seconds until road 1 / road 2 lamp changes
// ---------------------------------------------------------------------------
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1s,
    input  logic             ped_req,
    input  logic             night_mode,
    output logic             xanh_1,
    output logic             vang_1,
    output logic             do_1,
    output logic             xanh_2,
    output logic             vang_2,
    output logic             do_2,
    output logic             ped_walk,
    output logic [CNT_W-1:0] cnt_1,
    output logic [CNT_W-1:0] cnt_2
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED);
    // A pending pedestrian may cut the green once phase_left has dropped to
    // this value, i.e. once at least T_GREEN_MIN ticks of green have elapsed.
    localparam logic [CNT_W-1:0] CUT_LEFT  = CNT_W'(T_GREEN - T_GREEN_MIN);

    phase_t           state, state_n;
    logic [CNT_W-1:0] phase_left, phase_left_n;
    logic             ped_pend, ped_pend_n;
    logic             flash_ph, flash_ph_n;
    logic             walk, walk_n;
    logic [5:0]       lamp_q;

    // Next-phase decision. Everything only moves on tick_1s; a phase ends on
    // the tick that sees phase_left==1, so it lasts exactly its load value.
    // ped_req is OR-ed in every clk, and on the all-red entry clear the
    // fresh request is what survives, so a press on that clk is not lost.
    always_comb begin
        state_n      = state;
        phase_left_n = phase_left;
        ped_pend_n   = ped_pend | ped_req;
        flash_ph_n   = flash_ph;
        walk_n       = walk;
        if (tick_1s) begin
            case (state)
                G1, G2: begin
                    if (phase_left == ONE || (ped_pend && phase_left <= CUT_LEFT)) begin
                        state_n      = (state == G1) ? Y1 : Y2;
                        phase_left_n = LD_YELLOW;
                    end else begin
                        phase_left_n = phase_left - ONE;
                    end
                end
                Y1, Y2: begin
                    if (phase_left == ONE) begin
                        state_n      = (state == Y1) ? AR_A : AR_B;
                        phase_left_n = LD_ALLRED;
                        walk_n       = ped_pend;
                        ped_pend_n   = ped_req;
                    end else begin
                        phase_left_n = phase_left - ONE;
                    end
                end
                AR_A, AR_B: begin
                    if (phase_left == ONE) begin
                        walk_n = 1'b0;
                        if (night_mode) begin
                            state_n      = FLASH;
                            phase_left_n = LD_ALLRED;
                            flash_ph_n   = 1'b0;
                        end else begin
                            state_n      = (state == AR_A) ? G2 : G1;
                            phase_left_n = LD_GREEN;
                        end
                    end else begin
                        phase_left_n = phase_left - ONE;
                    end
                end
                FLASH: begin
                    if (!night_mode) begin
                        state_n      = AR_A;
                        phase_left_n = LD_ALLRED;
                        flash_ph_n   = 1'b0;
                    end else begin
                        flash_ph_n = ~flash_ph;
                    end
                end
                default: begin
                    state_n      = AR_A;
                    phase_left_n = LD_ALLRED;
                    walk_n       = 1'b0;
                end
            endcase
        end
    end

    // Scheduler state. Reset starts in a full all-red with nothing pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= AR_A;
            phase_left <= LD_ALLRED;
            ped_pend   <= 1'b0;
            flash_ph   <= 1'b0;
            walk       <= 1'b0;
        end else begin
            state      <= state_n;
            phase_left <= phase_left_n;
            ped_pend   <= ped_pend_n;
            flash_ph   <= flash_ph_n;
            walk       <= walk_n;
        end
    end

    // Lamps are decoded from the next state so they switch on the same edge
    // as the state register, one clk after the deciding tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lamp_q   <= LAMP_AR;
            ped_walk <= 1'b0;
        end else begin
            lamp_q   <= lamp_for(state_n, flash_ph_n);
            ped_walk <= walk_n;
        end
    end

    assign {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2} = lamp_q;

    traffic_cnt_calc #(
        .ROAD     (1),
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .CNT_W    (CNT_W)
    ) u_cnt_1 (
        .state      (state),
        .phase_left (phase_left),
        .cnt        (cnt_1)
    );

    traffic_cnt_calc #(
        .ROAD     (2),
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .CNT_W    (CNT_W)
    ) u_cnt_2 (
        .state      (state),
        .phase_left (phase_left),
        .cnt        (cnt_2)
    );

endmodule
